load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 126 ++++++++++++
 tb/tb_load_store_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one access at a time against a combinational-read,
// clocked-write data memory; sub-word stores are done as read-modify-write.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rd_data,
  output logic        mem_read,
  output logic        mem_write
);

  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP} state_t;

  state_t      state_q, state_n;
  logic        live_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic        err_q;

  logic        accept;
  logic        req_err;
  logic        wrap;

  assign accept = req_valid & req_ready;
  assign wrap   = req_addr > 32'hFFFF_FFFC;

  always_comb begin
    req_err = 1'b1;
    case (req_funct3)
      3'b000:  req_err = wrap;
      3'b001:  req_err = req_addr[0] | wrap;
      3'b010:  req_err = req_addr[1:0] != 2'b00;
      3'b100:  req_err = req_we | wrap;
      3'b101:  req_err = req_we | req_addr[0] | wrap;
      default: req_err = 1'b1;
    endcase
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)                  state_n = RESP;
          else if (!req_we)             state_n = LOAD;
          else if (req_funct3 == 3'b010) state_n = STORE;
          else                          state_n = RMW_RD;
        end
      end
      LOAD, STORE, RMW_WR: state_n = RESP;
      RMW_RD:              state_n = RMW_WR;
      RESP:                state_n = IDLE;
      default:             state_n = IDLE;
    endcase
  end

  // live_q keeps req_ready low until the first clock edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      live_q  <= 1'b1;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= req_err;
      end
      if (state_q == LOAD || state_q == RMW_RD)
        word_q <= mem_rd_data;
    end
  end

  assign req_ready  = live_q && (state_q == IDLE);
  assign mem_read   = (state_q == LOAD)  || (state_q == RMW_RD);
  assign mem_write  = (state_q == STORE) || (state_q == RMW_WR);
  assign mem_addr   = (mem_read || mem_write) ? addr_q : '0;
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid && err_q;

  always_comb begin
    mem_wr_data = '0;
    if (state_q == STORE)
      mem_wr_data = wdata_q;
    else if (state_q == RMW_WR)
      mem_wr_data = f3_q[0] ? {word_q[31:16], wdata_q[15:0]}
                            : {word_q[31:8],  wdata_q[7:0]};
  end

  always_comb begin
    resp_rdata = '0;
    if (resp_valid && !err_q && !we_q) begin
      case (f3_q)
        3'b000:  resp_rdata = {{24{word_q[7]}}, word_q[7:0]};
        3'b100:  resp_rdata = {24'h000000, word_q[7:0]};
        3'b001:  resp_rdata = {{16{word_q[15]}}, word_q[15:0]};
        3'b101:  resp_rdata = {16'h0000, word_q[15:0]};
        3'b010:  resp_rdata = word_q;
        default: resp_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 256-byte little-endian memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;
  logic        mem_read;
  logic        mem_write;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [7:0]  mem [256] = '{default: 8'h00};
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .mem_read(mem_read), .mem_write(mem_write)
  );

  always #5 clk = ~clk;

  logic [7:0] ra;
  assign ra = mem_addr[7:0];
  assign mem_rd_data = {mem[8'(ra + 8'd3)], mem[8'(ra + 8'd2)], mem[8'(ra + 8'd1)], mem[ra]};

  always @(posedge clk) begin
    if (pl_en) begin
      for (int i = 0; i < 4; i++) mem[8'(pl_addr + 8'(i))] <= pl_data[8*i +: 8];
    end else if (mem_write) begin
      for (int i = 0; i < 4; i++) mem[8'(ra + 8'(i))] <= mem_wr_data[8*i +: 8];
    end
  end

  function automatic logic [31:0] rd_word(input logic [7:0] a);
    return {mem[8'(a + 8'd3)], mem[8'(a + 8'd2)], mem[8'(a + 8'd1)], mem[a]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk);
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Starts and ends on a negedge with the unit idle.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_rd,
                        input int unsigned exp_lat, input int unsigned exp_rds,
                        input int unsigned exp_wrs, input logic [31:0] exp_wr_data);
    int unsigned lat = 0, rds = 0, wrs = 0, both = 0;
    logic [31:0] wr_seen = '0;
    logic got_err = 1'b0;
    logic [31:0] got_rd = '0;
    bit done = 0;
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
      if (mem_read && mem_write) both++;
      if (mem_read) rds++;
      if (mem_write) begin
        wrs++;
        wr_seen = mem_wr_data;
      end
      if (mem_read || mem_write) check({tag, "_maddr"}, mem_addr, addr);
      if (resp_valid) begin
        done = 1;
        got_err = resp_err;
        got_rd = resp_rdata;
        check({tag, "_maddr_idle"}, mem_addr, 32'd0);
      end
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_err"}, {31'd0, got_err}, {31'd0, exp_err});
    check({tag, "_rdata"}, got_rd, exp_rd);
    check({tag, "_reads"}, rds, exp_rds);
    check({tag, "_writes"}, wrs, exp_wrs);
    check({tag, "_rw_overlap"}, both, 32'd0);
    if (exp_wrs != 0) check({tag, "_wdata"}, wr_seen, exp_wr_data);
    @(negedge clk);
    check({tag, "_resp_1cyc"}, {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    int unsigned accepts, resps;
    bit prev_resp;

    @(negedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wr_data, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rel_ready", {31'd0, req_ready}, 32'd1);

    preload(8'h10, 32'h80FF7F01);
    preload(8'h20, 32'hAABBCCDD);
    preload(8'h2C, 32'h55667788);
    preload(8'h30, 32'h12345678);

    do_req("lb10",  1'b0, 3'b000, 32'h10, 32'h0, 1'b0, 32'h00000001, 2, 1, 0, 32'h0);
    do_req("lb13",  1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 32'hFFFFFF80, 2, 1, 0, 32'h0);
    do_req("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 32'h00000080, 2, 1, 0, 32'h0);
    do_req("lh12",  1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 32'hFFFF80FF, 2, 1, 0, 32'h0);
    do_req("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 32'h000080FF, 2, 1, 0, 32'h0);

    do_req("sb20",  1'b1, 3'b000, 32'h20, 32'h00000011, 1'b0, 32'h0, 3, 1, 1, 32'hAABBCC11);
    do_req("lw20",  1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'hAABBCC11, 2, 1, 0, 32'h0);
    do_req("sw24",  1'b1, 3'b010, 32'h24, 32'hDEADBEEF, 1'b0, 32'h0, 2, 0, 1, 32'hDEADBEEF);
    do_req("lw24",  1'b0, 3'b010, 32'h24, 32'h0, 1'b0, 32'hDEADBEEF, 2, 1, 0, 32'h0);
    do_req("sh2c",  1'b1, 3'b001, 32'h2C, 32'h1234CAFE, 1'b0, 32'h0, 3, 1, 1, 32'h5566CAFE);
    do_req("lw2c",  1'b0, 3'b010, 32'h2C, 32'h0, 1'b0, 32'h5566CAFE, 2, 1, 0, 32'h0);

    do_req("e_lw22",   1'b0, 3'b010, 32'h22, 32'h0, 1'b1, 32'h0, 1, 0, 0, 32'h0);
    do_req("e_lh21",   1'b0, 3'b001, 32'h21, 32'h0, 1'b1, 32'h0, 1, 0, 0, 32'h0);
    do_req("e_sbwrap", 1'b1, 3'b000, 32'hFFFFFFFE, 32'h5A, 1'b1, 32'h0, 1, 0, 0, 32'h0);
    do_req("e_ld011",  1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 1, 0, 0, 32'h0);
    do_req("e_st100",  1'b1, 3'b100, 32'h10, 32'h77, 1'b1, 32'h0, 1, 0, 0, 32'h0);

    // Reset landing in RMW_WR of SH 0x30
    req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h30; req_wdata = 32'h0000BEEF;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rmw_rd_strobe", {31'd0, mem_read}, 32'd1);
    @(negedge clk);
    check("rmw_wr_strobe", {31'd0, mem_write}, 32'd1);
    rst = 1'b0;
    #1;
    check("arst_mem_write", {31'd0, mem_write}, 32'd0);
    check("arst_mem_addr", mem_addr, 32'd0);
    check("arst_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("arst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("arst_mem_kept", rd_word(8'h30), 32'h12345678);
    rst = 1'b1;
    @(negedge clk);
    check("arst_rel_ready", {31'd0, req_ready}, 32'd1);
    check("arst_rel_resp", {31'd0, resp_valid}, 32'd0);
    do_req("lw30", 1'b0, 3'b010, 32'h30, 32'h0, 1'b0, 32'h12345678, 2, 1, 0, 32'h0);

    // Back-to-back stream with req_valid held high
    accepts = 0; resps = 0; prev_resp = 0;
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h24; req_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (req_ready) accepts++;
      if (resp_valid) begin
        resps++;
        check("stream_rdata", resp_rdata, 32'hDEADBEEF);
        check("stream_pulse", {31'd0, prev_resp}, 32'd0);
      end
      prev_resp = resp_valid;
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (resp_valid) resps++;
      @(negedge clk);
    end
    check("stream_accepts", accepts, 32'd10);
    check("stream_resps", resps, 32'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
